// File: rtl/mixcol_state_engine.sv
// Column-serial AES MixColumns / InvMixColumns engine.
// One 32-bit column is transformed in place per cycle, with a valid/ready handshake on each side.
module mixcol_state_engine #(
    parameter int NCOL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  control,
    input  logic [32*NCOL-1:0]    state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NCOL-1:0]    state_out,
    output logic                  busy
);

    localparam int CW = $clog2(NCOL);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_reg;
    logic [CW-1:0]       col_cnt_reg;
    logic [32*NCOL-1:0]  work_reg;
    logic [32*NCOL-1:0]  work_next;
    logic                mode_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;

    logic [31:0]         cols [NCOL];
    logic [31:0]         cur_col;
    logic [7:0]          a [4];
    logic [31:0]         mix_col;
    logic [31:0]         inv_col;
    logic [31:0]         new_col;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant via the xtime chain b, 2b, 4b, 8b.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p2;
        logic [7:0] p4;
        logic [7:0] p8;
        p2 = xt(b);
        p4 = xt(p2);
        p8 = xt(p4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? p2 : 8'h00) ^
               (k[2] ? p4 : 8'h00) ^ (k[3] ? p8 : 8'h00);
    endfunction

    generate
        for (genvar gi = 0; gi < NCOL; gi++) begin : g_cols
            assign cols[gi] = work_reg[32*(NCOL-1-gi) +: 32];
            assign work_next[32*(NCOL-1-gi) +: 32] =
                (col_cnt_reg == CW'(gi)) ? new_col : work_reg[32*(NCOL-1-gi) +: 32];
        end
    endgenerate

    assign cur_col = cols[col_cnt_reg];

    // Row gi of each matrix is the base row rotated right by gi bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rows
            assign a[gi] = cur_col[31-8*gi -: 8];
            assign mix_col[31-8*gi -: 8] = gmul(a[gi], 4'h2) ^ gmul(a[(gi+1)%4], 4'h3) ^
                                           a[(gi+2)%4] ^ a[(gi+3)%4];
            assign inv_col[31-8*gi -: 8] = gmul(a[gi], 4'he) ^ gmul(a[(gi+1)%4], 4'hb) ^
                                           gmul(a[(gi+2)%4], 4'hd) ^ gmul(a[(gi+3)%4], 4'h9);
        end
    endgenerate

    assign new_col = mode_reg ? mix_col : inv_col;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            col_cnt_reg   <= '0;
            work_reg      <= '0;
            mode_reg      <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        work_reg     <= state_in;
                        mode_reg     <= control;
                        col_cnt_reg  <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    work_reg    <= work_next;
                    col_cnt_reg <= col_cnt_reg + 1'b1;
                    if (col_cnt_reg == CW'(NCOL-1)) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign state_out = out_valid_reg ? work_reg : '0;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mixcol_state_engine.sv
// Directed bench for mixcol_state_engine: known AES column vectors, latency,
// output back-pressure, asynchronous reset abort and back-to-back operation.
module tb_mixcol_state_engine;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         control = 1'b0;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] V1_IN  = {32'h876e46a6, 96'h0};
    localparam logic [127:0] V1_OUT = {32'h473794ed, 96'h0};
    localparam logic [127:0] V3_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V3_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    mixcol_state_engine #(.NCOL(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a state at a negedge and hold it through the accepting edge;
    // afterwards keep in_valid high with junk to show it is ignored while busy.
    task automatic do_accept(input logic c, input logic [127:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        control  = c;
        state_in = d;
        @(posedge clk);
        #1;
        check("in_ready_after_accept", in_ready, 1'b0);
        control  = ~c;
        state_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Count cycles after the accepting edge until out_valid, then check data.
    task automatic wait_out(input string tag, input logic [127:0] exp);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "_busy"}, busy, 1'b1);
        end while (!out_valid && lat < 20);
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, 5);
        check({tag, "_data"}, state_out, exp);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_low"}, out_valid, 1'b0);
        check({tag, "_state_out_zero"}, state_out, 128'h0);
        check({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic c, input logic [127:0] d,
                          input logic [127:0] exp);
        do_accept(c, d);
        wait_out(tag, exp);
        consume(tag);
    endtask

    initial begin
        logic [127:0] held;
        int           rdy_cnt;

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state_out", state_out, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_before_first_edge", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("in_ready_first_edge", in_ready, 1'b1);

        // Single-column vectors, both directions
        run_op("mix_col0", 1'b1, V1_IN, V1_OUT);
        run_op("inv_col0", 1'b0, V1_OUT, V1_IN);

        // Full-state round trip
        run_op("mix_full", 1'b1, V3_IN, V3_OUT);
        run_op("inv_full", 1'b0, V3_OUT, V3_IN);

        // Back-pressure: DONE holds for 10 cycles while inputs toggle
        do_accept(1'b1, V3_IN);
        wait_out("hold", V3_OUT);
        held = state_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            control  = ~control;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("hold_state_out", state_out, V3_OUT);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        check("hold_accept_data", state_out, held);
        consume("hold");

        // Asynchronous reset in BUSY at col_cnt = 2
        do_accept(1'b1, V3_IN);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_state_out", state_out, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_output", out_valid, 1'b0);
        end
        run_op("post_abort_mix", 1'b1, V1_IN, V1_OUT);

        // Back-to-back Mix then Inv with out_ready held high
        out_ready = 1'b1;
        do_accept(1'b1, V3_IN);
        wait_out("b2b_mix", V3_OUT);
        in_valid = 1'b1;
        control  = 1'b0;
        state_in = V3_OUT;
        rdy_cnt  = 0;
        @(posedge clk);
        #1;
        check("b2b_out_valid_drop", out_valid, 1'b0);
        if (in_ready) rdy_cnt++;
        @(posedge clk);
        #1;
        if (in_ready) rdy_cnt++;
        check("b2b_in_ready_one_cycle", rdy_cnt, 1);
        control  = 1'b1;
        state_in = '0;
        wait_out("b2b_inv", V3_IN);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("b2b_final_out_valid", out_valid, 1'b0);
        check("b2b_final_in_ready", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mixcol_state_engine.md
MIXCOL_STATE_ENGINE -- requirements
Module: mixcol_state_engine

Interface
REQ-001 SHALL have exactly one parameter: NCOL, default 4, number of 32-bit columns per state; only 4 is supported.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 = reset.
REQ-004 SHALL have port in_valid, input, 1 bit: state_in and control are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: engine can accept a state.
REQ-006 SHALL have port control, input, 1 bit: 1 = MixColumns, 0 = InvMixColumns; sampled at input handshake.
REQ-007 SHALL have port state_in, input, 128 bits: column c = bits [127-32c -: 32]; byte A (row 0) is the column MSB.
REQ-008 SHALL have port out_valid, output, 1 bit: state_out holds a finished result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts state_out.
REQ-010 SHALL have port state_out, output, 128 bits: result, same column/byte layout as state_in.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL assert in_ready only in IDLE; in_ready SHALL depend on state only, never on in_valid.
REQ-014 SHALL, on in_valid&in_ready, latch state_in into the working register and control into a mode flag, clear col_cnt to 0, and go to BUSY.
REQ-015 SHALL, in BUSY, transform column col_cnt in place each cycle, then increment col_cnt.
REQ-016 SHALL use the Mix matrix rows {02 03 01 01} rotated per output byte.
REQ-017 SHALL use the Inv matrix rows {0E 0B 0D 09} rotated per output byte.
REQ-018 SHALL perform all arithmetic in GF(2^8) modulo x^8+x^4+x^3+x+1 (xtime: shift left, XOR 0x1B on carry), with 8-bit results only.
REQ-019 SHALL, when col_cnt = 3, transform the last column and move to DONE; col_cnt wraps to 0.
REQ-020 SHALL give a fixed latency of 5 cycles from the accepting edge to the first cycle with out_valid=1.
REQ-021 SHALL assert out_valid only in DONE, with state_out = working register, held stable until accepted.
REQ-022 SHALL, on out_valid&out_ready, return to IDLE; the next input is accepted no earlier than the following cycle.
REQ-023 SHALL ignore in_valid, control and state_in changes during BUSY and DONE; the latched mode is used for all four columns.
REQ-024 SHALL hold DONE indefinitely while out_ready=0, with no loss or change of data.
REQ-025 SHALL drive state_out = 0 whenever out_valid = 0.

Reset
REQ-026 SHALL, while reset=0 (asynchronously, including mid-BUSY or mid-DONE), force FSM=IDLE, col_cnt=0, working register=0, mode=0, in_ready=0, out_valid=0, busy=0, state_out=0.
REQ-027 SHALL assert in_ready on the first rising edge after reset deasserts; any aborted operation produces no output.

Verification
REQ-028 SHALL pass this case: control=1, column0=87 6E 46 A6, other columns 0 -> out column0=47 37 94 ED, others 00.
REQ-029 SHALL pass this case: control=0, column0=47 37 94 ED -> out column0=87 6E 46 A6, out_valid exactly 5 cycles after the accepting edge.
REQ-030 SHALL pass this case: control=1, state d4bf5d30 e0b452ae b84111f1 1e2798e5 -> 046681e5 e0cb199a 48f8d37a 2806264c; feeding that result back with control=0 returns the original.
REQ-031 SHALL pass this case: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, control and state_in -> state_out stable, in_ready=0; the result is accepted when out_ready=1.
REQ-032 SHALL pass this case: assert reset=0 asynchronously in BUSY at col_cnt=2 -> all outputs 0 immediately, no out_valid afterwards; a fresh vector after release gives the correct result.
REQ-033 SHALL pass this case: back-to-back Mix then Inv with out_ready=1 constantly -> two correct results, with in_ready high for one cycle between them.
